// File: rtl/peri_pkg.sv
// Shared register map and field layout for the peripheral target block.
// Imported by the target RTL, the decode stage and testbenches.
package peri_pkg;

    localparam int unsigned PERI_REG_W = 16;

    localparam logic [PERI_REG_W-1:0] PERI_CTRL    = 16'h0000;
    localparam logic [PERI_REG_W-1:0] PERI_TXDATA  = 16'h0001;
    localparam logic [PERI_REG_W-1:0] PERI_STATUS  = 16'h0002;
    localparam logic [PERI_REG_W-1:0] PERI_OVF_CLR = 16'h0003;

    localparam int unsigned CTRL_ENABLE = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned CTRL_FLUSH  = 2;

    localparam int unsigned STAT_OVF   = 15;
    localparam int unsigned STAT_FULL  = 14;
    localparam int unsigned STAT_EMPTY = 13;
    localparam int unsigned STAT_CNT_W = 8;

    typedef struct packed {
        logic                  overflow;
        logic                  full;
        logic                  empty;
        logic [4:0]            rsvd;
        logic [STAT_CNT_W-1:0] count;
    } status_t;

endpackage

// File: rtl/peri_fifo.sv
// Synchronous circular-buffer FIFO with first-word fall-through head,
// flush, and a drop indication for pushes that find the buffer full.
module peri_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] head_c,
    output logic              full_c,
    output logic              empty_c,
    output logic              empty_next_c,
    output logic              drop_c,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pop_ok, push_ok;

    // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
    always_comb begin
        full_c   = (count_q == CNT_W'(DEPTH));
        empty_c  = (count_q == '0);
        pop_ok   = pop && !empty_c && !flush;
        push_ok  = push && !flush && (!full_c || pop_ok);
        drop_c   = push && !flush && full_c && !pop_ok;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        empty_next_c = (count_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

    assign head_c = mem_q[rd_ptr_q];
    assign count  = count_q;

endmodule

// File: rtl/peri_target.sv
// Memory-mapped peripheral responder: CTRL/STATUS registers, a TX FIFO fed by
// core stores and drained over a valid/ready stream, and a level interrupt.
module peri_target
    import peri_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              peri_web,
    input  logic [ADDR_W-1:0] peri_addr,
    input  logic [DATA_W-1:0] peri_datao,
    output logic [DATA_W-1:0] peri_datai,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              irq
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              enable_q, enable_d;
    logic              irq_en_q, irq_en_d;
    logic              overflow_q, overflow_d;
    logic              irq_q, irq_d;
    logic [DATA_W-1:0] peri_datai_q, peri_datai_d;

    logic              ctrl_wr, tx_wr, ovf_clr, flush, pop;
    logic              fifo_full, fifo_empty, fifo_empty_next, fifo_drop;
    logic [CNT_W-1:0]  fifo_count;
    status_t           status;

    always_comb begin
        ctrl_wr   = !peri_web && (peri_addr == ADDR_W'(PERI_CTRL));
        tx_wr     = !peri_web && (peri_addr == ADDR_W'(PERI_TXDATA));
        ovf_clr   = !peri_web && (peri_addr == ADDR_W'(PERI_OVF_CLR));
        flush     = ctrl_wr && peri_datao[CTRL_FLUSH];
        out_valid = enable_q && !fifo_empty;
        pop       = out_valid && out_ready;
    end

    peri_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (tx_wr),
        .pop          (pop),
        .flush        (flush),
        .wdata        (peri_datao),
        .head_c       (out_data),
        .full_c       (fifo_full),
        .empty_c      (fifo_empty),
        .empty_next_c (fifo_empty_next),
        .drop_c       (fifo_drop),
        .count        (fifo_count)
    );

    // Register updates; a drop in the same cycle as OVF_CLR keeps overflow set.
    always_comb begin
        enable_d     = enable_q;
        irq_en_d     = irq_en_q;
        overflow_d   = overflow_q;
        peri_datai_d = peri_datai_q;
        status       = '0;
        if (ctrl_wr) begin
            enable_d = peri_datao[CTRL_ENABLE];
            irq_en_d = peri_datao[CTRL_IRQ_EN];
        end
        if (ovf_clr)   overflow_d = 1'b0;
        if (fifo_drop) overflow_d = 1'b1;
        irq_d = irq_en_d && (fifo_empty_next || overflow_d);

        status.overflow = overflow_q;
        status.full     = fifo_full;
        status.empty    = fifo_empty;
        status.count    = STAT_CNT_W'(fifo_count);
        if (peri_web) begin
            peri_datai_d = '0;
            if (peri_addr == ADDR_W'(PERI_CTRL)) begin
                peri_datai_d[CTRL_ENABLE] = enable_q;
                peri_datai_d[CTRL_IRQ_EN] = irq_en_q;
            end else if (peri_addr == ADDR_W'(PERI_STATUS)) begin
                peri_datai_d = DATA_W'(status);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_q     <= 1'b0;
            irq_en_q     <= 1'b0;
            overflow_q   <= 1'b0;
            irq_q        <= 1'b0;
            peri_datai_q <= '0;
        end else begin
            enable_q     <= enable_d;
            irq_en_q     <= irq_en_d;
            overflow_q   <= overflow_d;
            irq_q        <= irq_d;
            peri_datai_q <= peri_datai_d;
        end
    end

    assign peri_datai = peri_datai_q;
    assign irq        = irq_q;

endmodule
